multiplexer_21: RTL and testbench
=================================

MULTIPLEXER_21 -- requirements
Module: multiplexer_21

Interface
REQ-001 SHALL have parameter WIDTH, default 72, giving the data width of A, B, C and c_q.
REQ-002 SHALL have port clk, input, 1, the single clock; all registers update on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port A, input, WIDTH, the data operand selected when selectionLine=0.
REQ-005 SHALL have port B, input, WIDTH, the data operand selected when selectionLine=1.
REQ-006 SHALL have port selectionLine, input, 1, the select line.
REQ-007 SHALL have port in_valid, input, 1, qualifies A/B/selectionLine for the registered path.
REQ-008 SHALL have port C, output, WIDTH, the combinational mux result.
REQ-009 SHALL have port c_q, output, WIDTH, the registered mux result.
REQ-010 SHALL have port out_valid, output, 1, qualifies c_q.
REQ-011 SHALL have port par_q, output, WIDTH/8, registered even parity, one bit per byte of c_q.
REQ-012 SHALL have port sel_changes, output, 16, a saturating count of accepted select transitions.

Function
REQ-013 SHALL drive C = A when selectionLine=0 and C = B when selectionLine=1, purely combinationally (zero latency, independent of clk/rst).
REQ-014 SHALL drive C = A when selectionLine is X/Z, so that C is never undriven.
REQ-015 SHALL, on each rising clk edge with in_valid=1, load c_q with C and set out_valid=1 (one-cycle latency).
REQ-016 SHALL, on a rising clk edge with in_valid=0, hold c_q and par_q and clear out_valid to 0.
REQ-017 SHALL load par_q[i] with the XOR of C[8i+7:8i] on the same edge that loads c_q.
REQ-018 SHALL require WIDTH to be a multiple of 8; any other value is a configuration error flagged at elaboration.
REQ-019 SHALL keep a last-accepted-select register and SHALL increment sel_changes when an accepted selectionLine differs from it.
REQ-020 SHALL saturate sel_changes at 16'hFFFF without wrapping.
REQ-021 SHALL not count the first accepted sample after reset as a change.
REQ-022 SHALL let A/B changes and selectionLine changes in the same cycle act together: the registered result reflects the new operand under the new select.

Reset
REQ-023 SHALL, while rst=1, immediately force c_q=0, par_q=0, out_valid=0, sel_changes=0 and clear the first-sample flag, regardless of clk.
REQ-024 SHALL leave C unaffected by rst.
REQ-025 SHALL, on a reset asserted mid-operation, discard the in-flight sample; the first rising edge after rst deasserts with in_valid=1 produces out_valid=1.

Structure
REQ-026 SHALL place the WIDTH default (72) and the counter width (16) as constants in a shared package.
REQ-027 SHALL implement the per-byte parity in one sub-module, byte_parity, instantiated WIDTH/8 times.
REQ-028 SHALL need no state machine; the block is a combinational mux plus a register stage.

Verification
REQ-029 SHALL cover select 0: A=72'h123456789ABCDEF123, B=72'h43210FEDCBA9876543, sel=0 -> C=A immediately; with in_valid=1, c_q=A and out_valid=1 after one edge.
REQ-030 SHALL cover select 1: same A/B, sel=1 -> C=B; after the next edge c_q=B and sel_changes=1.
REQ-031 SHALL cover the extremes: A=0, B=all-ones, toggling sel 0/1 -> C alternates 0 and all-ones, and par_q alternates 9'h000 and 9'h000 (even parity of 8 ones).
REQ-032 SHALL cover nibble patterns: A=72'h111111111111111111, B=72'h222222222222222222, sel 0 then 1 -> C=A then C=B, with par_q=9'h000 in both cases.
REQ-033 SHALL cover async reset: assert rst between edges with out_valid=1 -> c_q, par_q, out_valid and sel_changes go to 0 before the next edge, while C still follows sel.
REQ-034 SHALL cover saturation: 70000 accepted alternating selects -> sel_changes holds 16'hFFFF.

Source files
------------

// File: rtl/multiplexer_21_pkg.sv
// Shared constants and helpers for the registered 2:1 multiplexer.
package multiplexer_21_pkg;

  localparam int DEFAULT_WIDTH = 72;
  localparam int CNT_W         = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/multiplexer_21_byte_parity.sv
// Even parity of one byte: XOR of its eight bits.
module byte_parity (
  input  logic [7:0] data,
  output logic       par
);

  // Reduction XOR, purely combinational.
  always_comb par = ^data;

endmodule

// File: rtl/multiplexer_21.sv
// 2:1 multiplexer with a combinational output, a registered copy carrying
// per-byte parity, and a saturating count of accepted select transitions.
module multiplexer_21
  import multiplexer_21_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 selectionLine,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     C,
  output logic [WIDTH-1:0]     c_q,
  output logic                 out_valid,
  output logic [WIDTH/8-1:0]   par_q,
  output logic [CNT_W-1:0]     sel_changes
);

  localparam int NB = WIDTH / 8;

  // Parity lanes assume whole bytes; reject anything else at elaboration.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : gBadWidth
    $error("multiplexer_21: WIDTH (%0d) must be a non-zero multiple of 8", WIDTH);
  end

  logic          selEff;
  logic [NB-1:0] parNext;
  logic          lastSel;
  logic          haveSel;

  // Select resolution: only a definite 1 picks B, so X/Z falls back to A.
  always_comb begin
    selEff = 1'b0;
    if (selectionLine) selEff = 1'b1;
  end

  // Combinational mux output, independent of clk and rst.
  always_comb begin
    C = A;
    if (selEff) C = B;
  end

  // One parity lane per byte of the mux result.
  for (genvar i = 0; i < NB; i++) begin : gPar
    byte_parity uPar (
      .data (C[8*i +: 8]),
      .par  (parNext[i])
    );
  end

  // Register stage: capture accepted samples, track select transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= '0;
      par_q       <= '0;
      out_valid   <= 1'b0;
      sel_changes <= '0;
      lastSel     <= 1'b0;
      haveSel     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c_q     <= C;
        par_q   <= parNext;
        lastSel <= selEff;
        haveSel <= 1'b1;
        // The first sample after reset has nothing to compare against.
        if (haveSel && (selEff != lastSel))
          sel_changes <= satInc(sel_changes);
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_21.sv
// Directed bench for multiplexer_21 with hand-computed expectations.
module tb_multiplexer_21;

  localparam int W = 72;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   A, B;
  logic           selectionLine;
  logic           in_valid;
  logic [W-1:0]   C, c_q;
  logic           out_valid;
  logic [W/8-1:0] par_q;
  logic [15:0]    sel_changes;

  int compared = 0;
  int mismatched = 0;

  localparam logic [W-1:0] VA   = 72'h123456789ABCDEF123;
  localparam logic [W-1:0] VB   = 72'h43210FEDCBA9876543;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] N1   = 72'h111111111111111111;
  localparam logic [W-1:0] N2   = 72'h222222222222222222;

  multiplexer_21 #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .selectionLine (selectionLine),
    .in_valid      (in_valid),
    .C             (C),
    .c_q           (c_q),
    .out_valid     (out_valid),
    .par_q         (par_q),
    .sel_changes   (sel_changes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; selectionLine = 1'b0; in_valid = 1'b0;
    step();
    chk("rst_cq",   c_q, '0);
    chk("rst_par",  W'(par_q), '0);
    chk("rst_ov",   W'(out_valid), '0);
    chk("rst_cnt",  W'(sel_changes), '0);

    // Select 0
    rst = 1'b0; A = VA; B = VB; selectionLine = 1'b0; in_valid = 1'b1;
    #1 chk("s0_C", C, VA);
    step();
    chk("s0_cq",  c_q, VA);
    chk("s0_ov",  W'(out_valid), 1);
    chk("s0_par", W'(par_q), 72'h08B);
    chk("s0_cnt", W'(sel_changes), 0);

    // Select 1
    selectionLine = 1'b1;
    #1 chk("s1_C", C, VB);
    step();
    chk("s1_cq",  c_q, VB);
    chk("s1_par", W'(par_q), 72'h111);
    chk("s1_cnt", W'(sel_changes), 1);

    // in_valid low: hold data, drop valid, no count
    in_valid = 1'b0; selectionLine = 1'b0;
    step();
    chk("hold_ov",  W'(out_valid), 0);
    chk("hold_cq",  c_q, VB);
    chk("hold_par", W'(par_q), 72'h111);
    chk("hold_cnt", W'(sel_changes), 1);
    chk("hold_C",   C, VA);

    // Extremes
    A = '0; B = ONES; in_valid = 1'b1; selectionLine = 1'b0;
    #1 chk("ext0_C", C, '0);
    step();
    chk("ext0_cq",  c_q, '0);
    chk("ext0_par", W'(par_q), 0);
    chk("ext0_cnt", W'(sel_changes), 2);
    selectionLine = 1'b1;
    #1 chk("ext1_C", C, ONES);
    step();
    chk("ext1_cq",  c_q, ONES);
    chk("ext1_par", W'(par_q), 0);
    chk("ext1_cnt", W'(sel_changes), 3);

    // Nibble patterns, operand and select changing together
    A = N1; B = N2; selectionLine = 1'b0;
    step();
    chk("nib0_cq",  c_q, N1);
    chk("nib0_par", W'(par_q), 0);
    selectionLine = 1'b1;
    step();
    chk("nib1_cq",  c_q, N2);
    chk("nib1_par", W'(par_q), 0);
    chk("nib_cnt",  W'(sel_changes), 5);

    // Unknown select falls back to A
    selectionLine = 1'bx;
    #1 chk("selx_C", C, N1);
    selectionLine = 1'b1;

    // Async reset between edges with out_valid high
    A = VA; B = VB;
    step();
    chk("pre_ov", W'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cq",  c_q, '0);
    chk("arst_par", W'(par_q), 0);
    chk("arst_ov",  W'(out_valid), 0);
    chk("arst_cnt", W'(sel_changes), 0);
    chk("arst_C1",  C, VB);
    selectionLine = 1'b0;
    #1 chk("arst_C0", C, VA);
    rst = 1'b0;
    step();
    chk("post_ov",  W'(out_valid), 1);
    chk("post_cq",  c_q, VA);
    chk("post_cnt", W'(sel_changes), 0);

    // Saturation
    for (int i = 0; i < 70000; i++) begin
      selectionLine = ~selectionLine;
      step();
    end
    chk("sat_cnt", W'(sel_changes), 72'hFFFF);
    selectionLine = ~selectionLine;
    step();
    chk("sat_hold", W'(sel_changes), 72'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
